pixel_streamer: RTL and testbench

// - Source end of the conv_layer_1 serial pixel interface: holds one binary IMG_H x IMG_W image and

---
 rtl/pixel_streamer.sv | 141 ++++++++++++++
 tb/tb_pixel_streamer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module  : pixel_streamer
// Holds one binary IMG_H x IMG_W image and streams it 1 pixel/clock in raster
// order with frame markers. Optional STREAM_CHECKSUM_EN adds ones_count.
// Rev 1.0 : initial release
// ============================================================================
module pixel_streamer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(IMG_H)-1:0]   wr_row,
  input  logic [IMG_W-1:0]           wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       pixel_out,
  output logic                       pixel_valid,
  output logic                       frame_start,
  output logic                       frame_end
`ifdef STREAM_CHECKSUM_EN
  ,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] ones_count
`endif
);

  localparam int C_RW = $clog2(IMG_H);
  localparam int C_CW = $clog2(IMG_W);
  localparam logic [C_RW-1:0] C_LAST_ROW = C_RW'(IMG_H - 1);
  localparam logic [C_CW-1:0] C_LAST_COL = C_CW'(IMG_W - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t            state_q;
  logic [C_RW-1:0]   row_q;
  logic [C_CW-1:0]   col_q;
  logic [IMG_W-1:0]  mem_q [IMG_H];
  logic              pix_q;
  logic              valid_q;
  logic              fs_q;
  logic              fe_q;
  logic              at_last;
  logic              wr_accept;

  assign at_last   = (row_q == C_LAST_ROW) && (col_q == C_LAST_COL);
  // The frame being transmitted is frozen: only IDLE-time writes land.
  assign wr_accept = wr_en && (state_q == S_IDLE) && (int'(wr_row) < IMG_H);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < IMG_H; r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_accept) begin
      mem_q[wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      pix_q   <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_STREAM;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        S_STREAM: begin
          pix_q   <= mem_q[row_q][col_q];
          valid_q <= 1'b1;
          fs_q    <= (row_q == '0) && (col_q == '0);
          fe_q    <= at_last;
          if (col_q == C_LAST_COL) begin
            col_q <= '0;
            if (at_last) begin
              row_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              row_q <= row_q + C_RW'(1);
            end
          end else begin
            col_q <= col_q + C_CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = valid_q;
  assign pixel_out   = pix_q;
  assign pixel_valid = valid_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;

`ifdef STREAM_CHECKSUM_EN
  localparam int C_NW = $clog2(IMG_W*IMG_H+1);

  logic [C_NW-1:0] acc_q;
  logic [C_NW-1:0] ones_q;

  // The last pixel is still in pix_q when frame_end is high, so it is folded in here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      ones_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        acc_q <= '0;
      end else if (valid_q) begin
        acc_q <= acc_q + C_NW'(pix_q);
      end
      if (fe_q) begin
        ones_q <= acc_q + C_NW'(pix_q);
      end
    end
  end

  assign ones_count = ones_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pixel_streamer
// Randomised self-checking bench; reference is an image array plus raster rule.
// Rev 1.0 : initial release
// ============================================================================
module tb_pixel_streamer;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int N    = W * H;
  localparam int NCAP = N + 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_row = '0;
  logic [W-1:0] wr_data = '0;
  logic         start = 1'b0;
  logic         busy, pixel_out, pixel_valid, frame_start, frame_end;
`ifdef STREAM_CHECKSUM_EN
  logic [9:0]   ones_count;
  logic [9:0]   co [NCAP];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] img [H];
  logic cv [NCAP];
  logic cp [NCAP];
  logic cs [NCAP];
  logic ce [NCAP];
  logic cb [NCAP];

  always #5 clk = ~clk;

  pixel_streamer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .start       (start),
    .busy        (busy),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end)
`ifdef STREAM_CHECKSUM_EN
    ,
    .ones_count  (ones_count)
`endif
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [W-1:0] d);
    wr_en = 1'b1; wr_row = 5'(r); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (r < H) img[r] = d;
  endtask

  task automatic clear_model();
    for (int r = 0; r < H; r++) img[r] = '0;
  endtask

  // Issues a start, records NCAP-1 cycles of outputs, then waits for idle.
  task automatic run_frame(input int wr_at, input logic [4:0] wr_r, input logic [W-1:0] wr_d,
                           input int start_at, input bit hold);
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    if (!hold) start = 1'b0;
    for (int k = 1; k < NCAP; k++) begin
      tick();
      cv[k] = pixel_valid; cp[k] = pixel_out; cs[k] = frame_start;
      ce[k] = frame_end;   cb[k] = busy;
`ifdef STREAM_CHECKSUM_EN
      co[k] = ones_count;
`endif
      wr_en = (k == wr_at); wr_row = wr_r; wr_data = wr_d;
      start = hold || (k == start_at);
    end
    wr_en = 1'b0; start = 1'b0;
    begin
      int guard;
      guard = 0;
      while (pixel_valid && guard < 3 * N) begin
        tick();
        guard++;
      end
      if (pixel_valid) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: pixel_valid=%b after %0d cycles, required 0", pixel_valid, guard);
      end
    end
  endtask

  // First raster cycle whose captured pixel/valid/busy disagrees with the model, or -1.
  function automatic int stream_err();
    for (int k = 1; k <= N; k++) begin
      int r, c;
      r = (k - 1) / W;
      c = (k - 1) % W;
      if (cv[k] !== 1'b1 || cb[k] !== 1'b1 || cp[k] !== img[r][c]) return k;
    end
    return -1;
  endfunction

  function automatic int marker_err();
    for (int k = 1; k <= N + 1; k++) begin
      if (cs[k] !== (k == 1) || ce[k] !== (k == N)) return k;
    end
    return -1;
  endfunction

  function automatic int model_ones();
    int s;
    s = 0;
    for (int r = 0; r < H; r++) s += $countones(img[r]);
    return s;
  endfunction

  task automatic test_reset();
    #23;
    n_cmp++;
    if ({busy, pixel_out, pixel_valid, frame_start, frame_end} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {busy, pixel_out, pixel_valid, frame_start, frame_end});
    end
    @(posedge clk); #1 rst = 1'b0;
    tick();
`ifdef STREAM_CHECKSUM_EN
    n_cmp++;
    if (ones_count !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_ones: got %0d, required 0", ones_count);
    end
`endif
    clear_model();
    run_frame(-1, '0, '0, -1, 1'b0);
    n_cmp++;
    if (stream_err() !== -1) begin
      n_bad++;
      $display("FAIL reset_mem_cleared: bad cycle %0d pixel %b, required all-zero frame",
               stream_err(), cp[stream_err()]);
    end
  endtask

  task automatic test_checkerboard();
    for (int r = 0; r < H; r++) begin
      logic [W-1:0] d;
      for (int c = 0; c < W; c++) d[c] = 1'((r + c) % 2);
      write_row(r, d);
    end
    run_frame(-1, '0, '0, -1, 1'b0);
    n_cmp++;
    if (stream_err() !== -1) begin
      n_bad++;
      $display("FAIL checker_stream: first bad cycle %0d, required -1", stream_err());
    end
    n_cmp++;
    if (marker_err() !== -1) begin
      n_bad++;
      $display("FAIL checker_markers: first bad cycle %0d (fs=%b fe=%b), required -1",
               marker_err(), cs[marker_err()], ce[marker_err()]);
    end
    n_cmp++;
    if ({cv[N+1], cb[N+1], cp[N+1]} !== 3'b000) begin
      n_bad++;
      $display("FAIL checker_idle_after: valid/busy/pixel %b, required 000", {cv[N+1], cb[N+1], cp[N+1]});
    end
`ifdef STREAM_CHECKSUM_EN
    n_cmp++;
    if (co[N+1] !== 10'd392 || co[N] !== 10'd0) begin
      n_bad++;
      $display("FAIL checker_ones: before=%0d after=%0d, required 0 then 392", co[N], co[N+1]);
    end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < 40; i++) begin
        write_row(int'($urandom_range(0, 31)), W'($urandom));
      end
      run_frame(-1, '0, '0, -1, 1'b0);
      n_cmp++;
      if (stream_err() !== -1) begin
        n_bad++;
        $display("FAIL random_stream_%0d: first bad cycle %0d, required -1", it, stream_err());
      end
`ifdef STREAM_CHECKSUM_EN
      n_cmp++;
      if (int'(co[N+1]) !== model_ones()) begin
        n_bad++;
        $display("FAIL random_ones_%0d: got %0d, required %0d", it, co[N+1], model_ones());
      end
`endif
    end
  endtask

  task automatic test_protected();
    for (int r = 0; r < H; r++) write_row(r, '0);
    run_frame(5, 5'd0, '1, -1, 1'b0);
    n_cmp++;
    if (stream_err() !== -1) begin
      n_bad++;
      $display("FAIL protect_frame: first bad cycle %0d, required all-zero frame", stream_err());
    end
    run_frame(-1, '0, '0, -1, 1'b0);
    n_cmp++;
    if (stream_err() !== -1) begin
      n_bad++;
      $display("FAIL protect_dropped: first bad cycle %0d, required write discarded", stream_err());
    end
    write_row(0, '1);
    run_frame(-1, '0, '0, -1, 1'b0);
    n_cmp++;
    if (stream_err() !== -1 || cp[1] !== 1'b1 || cp[W] !== 1'b1) begin
      n_bad++;
      $display("FAIL protect_row0_ones: bad cycle %0d p1=%b p28=%b, required row0 ones",
               stream_err(), cp[1], cp[W]);
    end
  endtask

  task automatic test_start_ignored();
    run_frame(-1, '0, '0, 300, 1'b0);
    n_cmp++;
    if (stream_err() !== -1 || marker_err() !== -1) begin
      n_bad++;
      $display("FAIL start_ignored_frame: stream %0d markers %0d, required -1 -1", stream_err(), marker_err());
    end
    begin
      int extra;
      extra = 0;
      for (int k = N + 1; k < NCAP; k++) extra += int'(cv[k]);
      n_cmp++;
      if (extra !== 0) begin
        n_bad++;
        $display("FAIL start_ignored_no_second: %0d valid cycles after frame, required 0", extra);
      end
    end
  endtask

  task automatic test_async_reset();
    write_row(0, '1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, pixel_valid, pixel_out, frame_start, frame_end} !== 5'b0) begin
      n_bad++;
      $display("FAIL async_reset_outputs: got %b, required 00000",
               {busy, pixel_valid, pixel_out, frame_start, frame_end});
    end
`ifdef STREAM_CHECKSUM_EN
    n_cmp++;
    if (ones_count !== 10'd0) begin
      n_bad++;
      $display("FAIL async_reset_ones: got %0d, required 0", ones_count);
    end
`endif
    @(posedge clk); #1 rst = 1'b0;
    clear_model();
    tick();
    run_frame(-1, '0, '0, -1, 1'b0);
    n_cmp++;
    if (cp[1] !== 1'b0 || cs[1] !== 1'b1 || stream_err() !== -1) begin
      n_bad++;
      $display("FAIL async_reset_restart: p00=%b fs=%b bad %0d, required 0 1 -1", cp[1], cs[1], stream_err());
    end
  endtask

  task automatic test_same_cycle();
    wr_en = 1'b1; wr_row = 5'd27; wr_data = '1;
    img[27] = '1;
    run_frame(-1, '0, '0, -1, 1'b0);
    begin
      int tail;
      tail = 0;
      for (int k = N - W + 1; k <= N; k++) tail += int'(cp[k]);
      n_cmp++;
      if (tail !== W || stream_err() !== -1) begin
        n_bad++;
        $display("FAIL same_cycle_write: last-row ones %0d bad %0d, required %0d -1", tail, stream_err(), W);
      end
    end
  endtask

  task automatic test_back_to_back();
    write_row(0, W'(28'h0000001));
    run_frame(-1, '0, '0, -1, 1'b1);
    n_cmp++;
    if ({cv[N], cv[N+1], cv[N+2], cs[N+2], cp[N+2]} !== {3'b101, 1'b1, img[0][0]}) begin
      n_bad++;
      $display("FAIL back_to_back_gap: v784 v785 v786 fs786 p786 = %b, required %b",
               {cv[N], cv[N+1], cv[N+2], cs[N+2], cp[N+2]}, {3'b101, 1'b1, img[0][0]});
    end
  endtask

  initial begin
    test_reset();
    test_checkerboard();
    test_random();
    test_protected();
    test_start_ignored();
    test_async_reset();
    test_same_cycle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
